exemplo_arbitro_rr: RTL and testbench
=====================================

Name: exemplo_arbitro_rr

Overview:
- Round-robin arbiter and sequencer that shares one compute datapath/controller pair between NUM_REQ requesters.
- Picks a requester and latches its operand onto the shared datapath input. Drives the controller's start-compute input and tracks the controller's 2-bit state (IDLE=00, COMPUTE=01, END=10) to detect completion.
- Returns a one-cycle acknowledge to the owning requester.
- Sits between the requester ports and the compute controller. It is the only driver of the controller's start input.

Parameters:
- NUM_REQ, 4, number of requesters; legal range 2..8.
- DATA_W, 8, operand width per requester.
- TIMEOUT, 15, maximum cycles allowed in any single state other than S_ARB before abort; legal range 4..255.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  reset, asynchronous, active-low.
- req_i  in  NUM_REQ  request per requester; held high until the matching ack_o.
- opa_i  in  NUM_REQ*DATA_W  operands; requester k occupies bits [k*DATA_W +: DATA_W].
- clr_err_i  in  1  synchronous clear of err_o.
- dp_state_i  in  2  compute controller state: 00 IDLE, 01 COMPUTE, 10 END; 11 is illegal.
- strt_cmpt_o  out  1  start-compute request to the controller.
- dp_a_o  out  DATA_W  latched operand of the current owner.
- gnt_o  out  NUM_REQ  one-hot grant, high for the whole transaction.
- ack_o  out  NUM_REQ  one-hot, one-cycle completion pulse to the owner.
- owner_o  out  $clog2(NUM_REQ)  index of the current or last owner.
- busy_o  out  1  high whenever FSM is not in S_ARB.
- err_o  out  1  sticky timeout/illegal-state flag.

Behaviour:
- All outputs are registered.
- Reset values:
  - strt_cmpt_o=0, dp_a_o=0, gnt_o=0, ack_o=0, owner_o=0, busy_o=0, err_o=0.
  - rr_ptr=0, timeout counter=0, FSM=S_ARB.
- Reset is asynchronous and may occur mid-transaction. It forces the reset values immediately; no ack is issued for the aborted transaction.
- Round-robin selection:
  - Search starts at rr_ptr and proceeds upward, wrapping from NUM_REQ-1 to 0.
  - The first k with req_i[k]=1 wins.
  - After each completed or aborted transaction, rr_ptr = (owner+1) mod NUM_REQ.
- S_ARB:
  - If any req_i is high: latch owner and opa_i slice of owner into dp_a_o; set gnt_o[owner]=1, strt_cmpt_o=1, busy_o=1; go to S_LAUNCH.
  - Otherwise stay in S_ARB with gnt_o=0.
- S_LAUNCH:
  - Hold strt_cmpt_o=1.
  - On dp_state_i=01, go to S_WAIT.
  - On dp_state_i=10 (compute completed already), take the S_WAIT exit directly.
- S_WAIT:
  - Hold strt_cmpt_o=1.
  - On dp_state_i=10: ack_o[owner]=1 for exactly one cycle, strt_cmpt_o=0, go to S_RELEASE.
- S_RELEASE:
  - strt_cmpt_o=0.
  - On dp_state_i=00: gnt_o=0, busy_o=0, advance rr_ptr, go to S_ARB.
- Latency, single uncontested request (edges counted from the first edge sampling req_i high):
  - Edge 1: grant and start asserted.
  - Edge 4: ack_o pulse.
  - Edge 6: back in S_ARB.
  - Minimum spacing between back-to-back grants: 6 cycles.
- Timeout:
  - The counter resets on every state change and increments in S_LAUNCH, S_WAIT and S_RELEASE.
  - When it reaches TIMEOUT: set err_o, strt_cmpt_o=0, gnt_o=0, no ack, advance rr_ptr, go to S_ARB.
- Illegal state: dp_state_i=11 in any non-ARB state sets err_o and aborts exactly like a timeout.
- err_o is sticky. It is cleared only by clr_err_i or reset. If clr_err_i and a new error occur in the same cycle, the error wins (err_o stays 1).
- Requests during a transaction:
  - Changes to req_i, or to the owner's opa_i slice, after the grant are ignored.
  - The operand and grant remain latched until completion.
  - A requester that drops req_i before being selected is skipped.
- ack_o and gnt_o are never asserted for a non-owner. ack_o is asserted at most once per grant.

Test Plan:
- Single request: req_i=0001, opa_i[7:0]=0x5A, controller model responds normally → gnt_o=0001 and dp_a_o=0x5A at edge 1; ack_o=0001 pulses one cycle at edge 4; busy_o falls at edge 6; owner_o=0.
- Fairness: req_i=1111 held for four transactions → grants in order 0,1,2,3, then wrap to 0. Each requester acked exactly once per round.
- Wrap-around with gaps: rr_ptr=3, req_i=0101 → requester 0 granted (wrap), next grant goes to requester 2.
- Timeout: controller model stuck at dp_state_i=00 after grant → at TIMEOUT=15 cycles in S_LAUNCH, err_o=1, strt_cmpt_o=0, gnt_o=0, no ack; err_o stays 1 until clr_err_i pulse.
- Reset mid-operation: assert rst_i=0 while in S_WAIT → all outputs reset asynchronously; after release with req_i=0010, requester 1 granted (rr_ptr restarted at 0).
- Request change during transaction: owner changes opa_i and other requesters toggle req_i while in S_WAIT → dp_a_o unchanged, gnt_o unchanged, single ack to original owner only.

Source files
------------

// File: rtl/exemplo_arbitro_rr.sv
// Round-robin arbiter/sequencer sharing one compute controller between NUM_REQ requesters.
// Latches the winner's operand, drives start-compute, tracks controller state, acks the owner.
module exemplo_arbitro_rr #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 8,
    parameter int TIMEOUT = 15
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic [NUM_REQ-1:0]          req_i,
    input  logic [NUM_REQ*DATA_W-1:0]   opa_i,
    input  logic                        clr_err_i,
    input  logic [1:0]                  dp_state_i,
    output logic                        strt_cmpt_o,
    output logic [DATA_W-1:0]           dp_a_o,
    output logic [NUM_REQ-1:0]          gnt_o,
    output logic [NUM_REQ-1:0]          ack_o,
    output logic [$clog2(NUM_REQ)-1:0]  owner_o,
    output logic                        busy_o,
    output logic                        err_o
);
    localparam int IW = $clog2(NUM_REQ);
    localparam int CW = $clog2(TIMEOUT + 1);

    localparam logic [1:0] DP_IDLE = 2'b00;
    localparam logic [1:0] DP_CMPT = 2'b01;
    localparam logic [1:0] DP_END  = 2'b10;
    localparam logic [1:0] DP_ILL  = 2'b11;

    typedef enum logic [1:0] {S_ARB, S_LAUNCH, S_WAIT, S_RELEASE} state_t;

    state_t               state, nxt_state;
    logic [IW-1:0]        rr_ptr, nxt_rr_ptr, pick, idx, nxt_owner;
    logic                 pick_vld, do_done, do_abort, tmo_hit;
    logic [CW-1:0]        tmo_cnt, nxt_tmo_cnt;
    logic                 nxt_strt, nxt_busy, nxt_err;
    logic [DATA_W-1:0]    nxt_dp_a;
    logic [NUM_REQ-1:0]   nxt_gnt, nxt_ack;

    // First requester at or above rr_ptr, wrapping.
    always_comb begin
        pick     = '0;
        pick_vld = 1'b0;
        idx      = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = IW'((int'(rr_ptr) + i) % NUM_REQ);
            if (!pick_vld && req_i[idx]) begin
                pick     = idx;
                pick_vld = 1'b1;
            end
        end
    end

    assign tmo_hit = (tmo_cnt == CW'(TIMEOUT - 1));

    always_comb begin
        nxt_state  = state;
        nxt_strt   = strt_cmpt_o;
        nxt_dp_a   = dp_a_o;
        nxt_gnt    = gnt_o;
        nxt_ack    = '0;
        nxt_owner  = owner_o;
        nxt_busy   = busy_o;
        nxt_err    = clr_err_i ? 1'b0 : err_o;
        nxt_rr_ptr = rr_ptr;
        do_done    = 1'b0;
        do_abort   = 1'b0;

        case (state)
            S_ARB: begin
                if (pick_vld) begin
                    nxt_owner = pick;
                    nxt_dp_a  = opa_i[pick*DATA_W +: DATA_W];
                    nxt_gnt   = NUM_REQ'(1) << pick;
                    nxt_strt  = 1'b1;
                    nxt_busy  = 1'b1;
                    nxt_state = S_LAUNCH;
                end else begin
                    nxt_gnt = '0;
                end
            end
            S_LAUNCH: begin
                if (dp_state_i == DP_ILL)       do_abort  = 1'b1;
                else if (dp_state_i == DP_CMPT) nxt_state = S_WAIT;
                else if (dp_state_i == DP_END)  do_done   = 1'b1;
                else if (tmo_hit)               do_abort  = 1'b1;
            end
            S_WAIT: begin
                if (dp_state_i == DP_ILL)      do_abort = 1'b1;
                else if (dp_state_i == DP_END) do_done  = 1'b1;
                else if (tmo_hit)              do_abort = 1'b1;
            end
            S_RELEASE: begin
                if (dp_state_i == DP_ILL) begin
                    do_abort = 1'b1;
                end else if (dp_state_i == DP_IDLE) begin
                    nxt_gnt    = '0;
                    nxt_busy   = 1'b0;
                    nxt_rr_ptr = (owner_o == IW'(NUM_REQ - 1)) ? '0 : owner_o + 1'b1;
                    nxt_state  = S_ARB;
                end else if (tmo_hit) begin
                    do_abort = 1'b1;
                end
            end
            default: nxt_state = S_ARB;
        endcase

        if (do_done) begin
            nxt_ack   = gnt_o;
            nxt_strt  = 1'b0;
            nxt_state = S_RELEASE;
        end
        // Abort: error wins over a same-cycle clear; no ack for the dropped transaction.
        if (do_abort) begin
            nxt_err    = 1'b1;
            nxt_strt   = 1'b0;
            nxt_gnt    = '0;
            nxt_busy   = 1'b0;
            nxt_rr_ptr = (owner_o == IW'(NUM_REQ - 1)) ? '0 : owner_o + 1'b1;
            nxt_state  = S_ARB;
        end

        nxt_tmo_cnt = (nxt_state != state || state == S_ARB) ? '0 : tmo_cnt + 1'b1;
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state       <= S_ARB;
            rr_ptr      <= '0;
            tmo_cnt     <= '0;
            strt_cmpt_o <= 1'b0;
            dp_a_o      <= '0;
            gnt_o       <= '0;
            ack_o       <= '0;
            owner_o     <= '0;
            busy_o      <= 1'b0;
            err_o       <= 1'b0;
        end else begin
            state       <= nxt_state;
            rr_ptr      <= nxt_rr_ptr;
            tmo_cnt     <= nxt_tmo_cnt;
            strt_cmpt_o <= nxt_strt;
            dp_a_o      <= nxt_dp_a;
            gnt_o       <= nxt_gnt;
            ack_o       <= nxt_ack;
            owner_o     <= nxt_owner;
            busy_o      <= nxt_busy;
            err_o       <= nxt_err;
        end
    end
endmodule

// File: tb/tb_exemplo_arbitro_rr.sv
// Directed bench for exemplo_arbitro_rr with a small compute-controller model.
module tb_exemplo_arbitro_rr;
    logic        clk_i = 1'b0;
    logic        rst_i;
    logic [3:0]  req_i;
    logic [31:0] opa_i;
    logic        clr_err_i;
    logic [1:0]  dp_state_i;
    logic        strt_cmpt_o;
    logic [7:0]  dp_a_o;
    logic [3:0]  gnt_o;
    logic [3:0]  ack_o;
    logic [1:0]  owner_o;
    logic        busy_o;
    logic        err_o;

    int nchk = 0;
    int nerr = 0;

    logic [31:0] opa_base = 32'hC3B2_A15A;
    logic [7:0]  opa_tab [4] = '{8'h5A, 8'hA1, 8'hB2, 8'hC3};

    // controller model: IDLE -start-> COMPUTE -> END -start low-> IDLE
    logic [1:0] mdl;
    logic       stuck = 1'b0;
    logic       force_ill = 1'b0;
    int         ack_cnt [4] = '{0, 0, 0, 0};

    exemplo_arbitro_rr #(.NUM_REQ(4), .DATA_W(8), .TIMEOUT(15)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .req_i(req_i), .opa_i(opa_i),
        .clr_err_i(clr_err_i), .dp_state_i(dp_state_i),
        .strt_cmpt_o(strt_cmpt_o), .dp_a_o(dp_a_o), .gnt_o(gnt_o),
        .ack_o(ack_o), .owner_o(owner_o), .busy_o(busy_o), .err_o(err_o)
    );

    always #5 clk_i = ~clk_i;

    always @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) mdl <= 2'b00;
        else case (mdl)
            2'b00:   if (strt_cmpt_o && !stuck) mdl <= 2'b01;
            2'b01:   mdl <= 2'b10;
            2'b10:   if (!strt_cmpt_o) mdl <= 2'b00;
            default: mdl <= 2'b00;
        endcase
    end
    assign dp_state_i = force_ill ? 2'b11 : mdl;

    always @(negedge clk_i)
        for (int k = 0; k < 4; k++) if (ack_o[k]) ack_cnt[k]++;

    task automatic tick;
        @(posedge clk_i);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nchk++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One full transaction for requester own; waits are cycle-bounded.
    task automatic run_txn(input int own, input bit clr_own, input bit disturb);
        logic [3:0] m;
        int c;
        m = 4'b0001 << own;
        c = 0;
        while (gnt_o == 4'b0 && c < 20) begin tick(); c++; end
        check("txn_gnt", gnt_o, m);
        check("txn_owner", owner_o, own);
        check("txn_dp_a", dp_a_o, opa_tab[own]);
        c = 0;
        while (ack_o == 4'b0 && c < 40) begin
            if (disturb) begin
                req_i = m | (4'($urandom_range(0, 15)) & ~m);
                opa_i[own*8 +: 8] = 8'($urandom_range(0, 255));
            end
            tick();
            if (disturb && ack_o == 4'b0) begin
                check("dist_dp_a", dp_a_o, opa_tab[own]);
                check("dist_gnt", gnt_o, m);
            end
            c++;
        end
        check("txn_ack", ack_o, m);
        if (clr_own) req_i = req_i & ~m;
        if (disturb) req_i = 4'b0;
        opa_i = opa_base;
        tick();
        check("txn_ack_1cyc", ack_o, 4'b0);
        c = 0;
        while (busy_o && c < 20) begin tick(); c++; end
        check("txn_busy_low", busy_o, 1'b0);
        check("txn_gnt_low", gnt_o, 4'b0);
    endtask

    initial begin
        int a0 [4];
        logic [3:0] ack_seen;
        rst_i = 1'b0; req_i = 4'b0; opa_i = opa_base; clr_err_i = 1'b0;
        #2;
        check("rst_strt", strt_cmpt_o, 1'b0);
        check("rst_dp_a", dp_a_o, 8'h00);
        check("rst_gnt", gnt_o, 4'b0);
        check("rst_ack", ack_o, 4'b0);
        check("rst_owner", owner_o, 2'd0);
        check("rst_busy", busy_o, 1'b0);
        check("rst_err", err_o, 1'b0);
        tick(); tick();
        rst_i = 1'b1;
        tick();

        // single request, exact latency
        req_i = 4'b0001;
        tick();
        check("s_gnt_e1", gnt_o, 4'b0001);
        check("s_dp_a_e1", dp_a_o, 8'h5A);
        check("s_strt_e1", strt_cmpt_o, 1'b1);
        check("s_busy_e1", busy_o, 1'b1);
        check("s_owner_e1", owner_o, 2'd0);
        tick(); tick();
        check("s_ack_e3", ack_o, 4'b0);
        tick();
        check("s_ack_e4", ack_o, 4'b0001);
        check("s_strt_e4", strt_cmpt_o, 1'b0);
        req_i = 4'b0;
        tick();
        check("s_ack_e5", ack_o, 4'b0);
        check("s_busy_e5", busy_o, 1'b1);
        tick();
        check("s_busy_e6", busy_o, 1'b0);
        check("s_gnt_e6", gnt_o, 4'b0);

        // fairness from a fresh pointer
        rst_i = 1'b0; #2; rst_i = 1'b1;
        tick();
        for (int k = 0; k < 4; k++) a0[k] = ack_cnt[k];
        req_i = 4'b1111;
        run_txn(0, 0, 0);
        run_txn(1, 0, 0);
        run_txn(2, 0, 0);
        run_txn(3, 0, 0);
        run_txn(0, 1, 0);
        req_i = 4'b0;
        check("fair_ack0", ack_cnt[0] - a0[0], 2);
        check("fair_ack1", ack_cnt[1] - a0[1], 1);
        check("fair_ack2", ack_cnt[2] - a0[2], 1);
        check("fair_ack3", ack_cnt[3] - a0[3], 1);

        // wrap with gaps: pointer 1 -> owner 2, pointer 3 -> 0 then 2
        req_i = 4'b0100;
        run_txn(2, 1, 0);
        req_i = 4'b0101;
        run_txn(0, 1, 0);
        run_txn(2, 1, 0);

        // input churn during transaction; pointer 3 -> owner 1
        req_i = 4'b0010;
        run_txn(1, 1, 1);

        // timeout: controller never leaves IDLE; pointer 2 -> owner 2
        stuck = 1'b1;
        req_i = 4'b0100;
        tick();
        check("to_gnt_e1", gnt_o, 4'b0100);
        ack_seen = 4'b0;
        for (int i = 0; i < 14; i++) begin tick(); ack_seen |= ack_o; end
        check("to_err_e15", err_o, 1'b0);
        check("to_gnt_e15", gnt_o, 4'b0100);
        tick();
        ack_seen |= ack_o;
        check("to_err_e16", err_o, 1'b1);
        check("to_strt_e16", strt_cmpt_o, 1'b0);
        check("to_gnt_e16", gnt_o, 4'b0);
        check("to_busy_e16", busy_o, 1'b0);
        check("to_no_ack", ack_seen, 4'b0);
        req_i = 4'b0; stuck = 1'b0;
        tick(); tick(); tick();
        check("to_err_sticky", err_o, 1'b1);
        clr_err_i = 1'b1; tick(); clr_err_i = 1'b0;
        check("to_err_clr", err_o, 1'b0);

        // reset in S_WAIT; pointer 3 -> owner 2
        req_i = 4'b0100;
        tick();
        check("mr_gnt", gnt_o, 4'b0100);
        tick(); tick();
        #2 rst_i = 1'b0;
        #1;
        check("mr_gnt_rst", gnt_o, 4'b0);
        check("mr_strt_rst", strt_cmpt_o, 1'b0);
        check("mr_busy_rst", busy_o, 1'b0);
        check("mr_dp_a_rst", dp_a_o, 8'h00);
        check("mr_owner_rst", owner_o, 2'd0);
        check("mr_ack_rst", ack_o, 4'b0);
        req_i = 4'b1100;
        #2 rst_i = 1'b1;
        run_txn(2, 1, 0);
        req_i = 4'b0;

        // illegal controller state with simultaneous clear; pointer 3 -> owner 3
        req_i = 4'b1000;
        tick();
        check("il_gnt", gnt_o, 4'b1000);
        force_ill = 1'b1; clr_err_i = 1'b1;
        tick();
        check("il_err", err_o, 1'b1);
        check("il_gnt_low", gnt_o, 4'b0);
        check("il_strt", strt_cmpt_o, 1'b0);
        check("il_ack", ack_o, 4'b0);
        force_ill = 1'b0; clr_err_i = 1'b0; req_i = 4'b0;
        tick();
        check("il_err_sticky", err_o, 1'b1);
        clr_err_i = 1'b1; tick(); clr_err_i = 1'b0;
        check("il_err_clr", err_o, 1'b0);
        tick(); tick(); tick();

        // pointer back at 0 -> requester 1 with only req 1
        req_i = 4'b0010;
        run_txn(1, 1, 0);

        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end
endmodule
